// File: rtl/injector_if.sv
// injector_if: ejector-side channels, local injection port
// and registered channel outputs of the injector.
interface injector_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [9:0]    nad;
  logic [9:0]    sad;
  logic [9:0]    ead;
  logic [9:0]    wad;
  logic [9:0]    inj_flit;
  logic          inj_valid;
  logic          inj_ready;
  logic [9:0]    nout;
  logic [9:0]    sout;
  logic [9:0]    eout;
  logic [9:0]    wout;
  logic          starve;
  logic [CW-1:0] fifo_cnt;

  modport master (
    output nad, sad, ead, wad,
    output inj_flit, inj_valid,
    input  inj_ready,
    input  nout, sout, eout, wout,
    input  starve, fifo_cnt
  );

  modport slave (
    input  nad, sad, ead, wad,
    input  inj_flit, inj_valid,
    output inj_ready,
    output nout, sout, eout, wout,
    output starve, fifo_cnt
  );
endinterface

// File: rtl/injector.sv
// injector: queues local flits and drops the FIFO head into
// the first free N/S/E/W slot. Macro INJECTOR_STARVE_CNT_EN.
module injector #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 15
) (
  input logic       clk,
  input logic       rst_n,
  injector_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [9:0]    r_mem [DEPTH];
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [CW-1:0] r_cnt;
  logic [9:0]    r_nout;
  logic [9:0]    r_sout;
  logic [9:0]    r_eout;
  logic [9:0]    r_wout;

  logic [3:0]    w_free;
  logic [3:0]    w_sel;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [9:0]    w_head;
  logic [9:0]    w_wdat;

  assign w_free  = {~bus.wad[9], ~bus.ead[9],
                    ~bus.sad[9], ~bus.nad[9]};
  assign w_full  = (r_cnt == CW'(DEPTH));
  assign w_empty = (r_cnt == '0);
  assign w_push  = bus.inj_valid & ~w_full;
  assign w_pop   = ~w_empty & (|w_free);
  assign w_head  = r_mem[r_rd];
  // stored flits are always marked valid
  assign w_wdat  = bus.inj_flit | 10'h200;

  // pick the first free slot in N, S, E, W order
  always_comb begin
    w_sel = 4'b0000;
    if (w_pop) begin
      priority case (1'b1)
        w_free[0]: w_sel = 4'b0001;
        w_free[1]: w_sel = 4'b0010;
        w_free[2]: w_sel = 4'b0100;
        default:   w_sel = 4'b1000;
      endcase
    end
  end

  // FIFO storage; full refuses a push even if popping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr] <= w_wdat;
    end
  end

  // pointers wrap naturally, DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push)
        r_wr <= r_wr + PW'(1);
      if (w_pop)
        r_rd <= r_rd + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // one-cycle channel stage with head substitution
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nout <= '0;
      r_sout <= '0;
      r_eout <= '0;
      r_wout <= '0;
    end else begin
      r_nout <= w_sel[0] ? w_head : bus.nad;
      r_sout <= w_sel[1] ? w_head : bus.sad;
      r_eout <= w_sel[2] ? w_head : bus.ead;
      r_wout <= w_sel[3] ? w_head : bus.wad;
    end
  end

  assign bus.nout      = r_nout;
  assign bus.sout      = r_sout;
  assign bus.eout      = r_eout;
  assign bus.wout      = r_wout;
  assign bus.fifo_cnt  = r_cnt;
  assign bus.inj_ready = ~w_full;

`ifdef INJECTOR_STARVE_CNT_EN
  localparam int BW =
    (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic          w_blk;
  logic [BW-1:0] w_blk_nxt;
  logic [BW-1:0] r_blk;
  logic          r_starve;

  assign w_blk = ~w_empty & ~(|w_free);

  // saturating run length of blocked cycles
  always_comb begin
    w_blk_nxt = '0;
    if (w_blk) begin
      if (r_blk >= BW'(STARVE_LIMIT))
        w_blk_nxt = r_blk;
      else
        w_blk_nxt = r_blk + BW'(1);
    end
  end

  // flag tracks the counter reaching the limit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blk    <= '0;
      r_starve <= 1'b0;
    end else begin
      r_blk    <= w_blk_nxt;
      r_starve <= (w_blk_nxt >= BW'(STARVE_LIMIT));
    end
  end

  assign bus.starve = r_starve;
`else
  // counter not built; flag held low
  assign bus.starve = 1'b0 & (STARVE_LIMIT > 0);
`endif
endmodule

// File: tb/tb_injector.sv
// tb_injector: vector table, hand sequences and a
// queue-based reference model under random traffic.
module tb_injector;
  localparam int DEPTH = 4;
  localparam int LIMIT = 15;
`ifdef INJECTOR_STARVE_CNT_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_run;
  int   n_fail;

  injector_if #(.DEPTH(DEPTH)) bus ();

  injector #(
    .DEPTH(DEPTH),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [9:0] n, s, e, w, flit;
    bit         vld;
    logic [9:0] en, es, ee, ew;
    int         cnt;
    bit         rdy;
  } vec_t;

  vec_t tbl [14];

  // reference model: a plain queue of stored flits
  logic [9:0]      mq [$];
  int              mblk;
  logic [3:0][9:0] ex_ch;
  int              ex_cnt;
  bit              ex_rdy;
  bit              ex_stv;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic [3:0][9:0] ch,
                            input logic [9:0] flit,
                            input bit vld);
    bit room;
    int slot;
    room  = (mq.size() < DEPTH);
    ex_ch = ch;
    slot  = -1;
    if (mq.size() > 0)
      for (int k = 0; k < 4; k++)
        if (slot < 0 && !ch[k][9]) slot = k;
    if (mq.size() > 0 && slot < 0)
      mblk = (mblk < LIMIT) ? mblk + 1 : mblk;
    else
      mblk = 0;
    if (slot >= 0) ex_ch[slot] = mq.pop_front();
    if (vld && room) mq.push_back({1'b1, flit[8:0]});
    ex_cnt = mq.size();
    ex_rdy = (mq.size() < DEPTH);
    ex_stv = STARVE_EN && (mblk >= LIMIT);
  endtask

  task automatic drive(input logic [3:0][9:0] ch,
                       input logic [9:0] flit,
                       input bit vld);
    bus.nad       = ch[0];
    bus.sad       = ch[1];
    bus.ead       = ch[2];
    bus.wad       = ch[3];
    bus.inj_flit  = flit;
    bus.inj_valid = vld;
  endtask

  // one checked clock against the model
  task automatic cycle(input logic [3:0][9:0] ch,
                       input logic [9:0] flit,
                       input bit vld);
    drive(ch, flit, vld);
    chk("ready_pre", 32'(bus.inj_ready),
        32'(mq.size() < DEPTH));
    model_step(ch, flit, vld);
    @(posedge clk);
    #1;
    chk("nout", 32'(bus.nout), 32'(ex_ch[0]));
    chk("sout", 32'(bus.sout), 32'(ex_ch[1]));
    chk("eout", 32'(bus.eout), 32'(ex_ch[2]));
    chk("wout", 32'(bus.wout), 32'(ex_ch[3]));
    chk("cnt", 32'(bus.fifo_cnt), 32'(ex_cnt));
    chk("ready", 32'(bus.inj_ready), 32'(ex_rdy));
    chk("starve", 32'(bus.starve), 32'(ex_stv));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive('0, '0, 1'b0);
    mq.delete();
    mblk = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [3:0][9:0] all_v;
  logic [3:0][9:0] rch;
  int              p;

  initial begin
    n_run  = 0;
    n_fail = 0;
    all_v  = {10'h204, 10'h203, 10'h202, 10'h201};

    tbl[0]  = '{10'h201, 0, 0, 0, 10'h005, 1,
                10'h201, 0, 0, 0, 1, 1};
    tbl[1]  = '{10'h201, 0, 0, 0, 10'h000, 0,
                10'h201, 10'h205, 0, 0, 0, 1};
    tbl[2]  = '{0, 0, 0, 0, 10'h0AA, 1,
                0, 0, 0, 0, 1, 1};
    tbl[3]  = '{0, 0, 0, 0, 10'h000, 0,
                10'h2AA, 0, 0, 0, 0, 1};
    tbl[4]  = '{10'h201, 10'h202, 10'h203, 10'h204,
                10'h011, 1,
                10'h201, 10'h202, 10'h203, 10'h204, 1, 1};
    tbl[5]  = '{10'h201, 10'h202, 10'h203, 10'h204,
                10'h012, 1,
                10'h201, 10'h202, 10'h203, 10'h204, 2, 1};
    tbl[6]  = '{10'h201, 10'h202, 10'h203, 10'h204,
                10'h013, 1,
                10'h201, 10'h202, 10'h203, 10'h204, 3, 1};
    tbl[7]  = '{10'h201, 10'h202, 10'h203, 10'h204,
                10'h014, 1,
                10'h201, 10'h202, 10'h203, 10'h204, 4, 0};
    tbl[8]  = '{10'h201, 10'h202, 10'h203, 10'h055,
                10'h015, 1,
                10'h201, 10'h202, 10'h203, 10'h211, 3, 1};
    tbl[9]  = '{10'h0F0, 10'h001, 10'h1FF, 10'h000,
                10'h000, 0,
                10'h212, 10'h001, 10'h1FF, 10'h000, 2, 1};
    tbl[10] = '{10'h3F0, 10'h123, 10'h000, 10'h000,
                10'h1C7, 1,
                10'h3F0, 10'h213, 10'h000, 10'h000, 2, 1};
    tbl[11] = '{10'h201, 10'h202, 10'h203, 10'h204,
                10'h000, 0,
                10'h201, 10'h202, 10'h203, 10'h204, 2, 1};
    tbl[12] = '{10'h201, 10'h202, 10'h000, 10'h204,
                10'h000, 0,
                10'h201, 10'h202, 10'h214, 10'h204, 1, 1};
    tbl[13] = '{0, 0, 0, 0, 10'h000, 0,
                10'h3C7, 0, 0, 0, 0, 1};

    // reset state
    rst_n = 1'b0;
    drive('0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_nout", 32'(bus.nout), 0);
    chk("rst_sout", 32'(bus.sout), 0);
    chk("rst_eout", 32'(bus.eout), 0);
    chk("rst_wout", 32'(bus.wout), 0);
    chk("rst_cnt", 32'(bus.fifo_cnt), 0);
    chk("rst_ready", 32'(bus.inj_ready), 1);
    chk("rst_starve", 32'(bus.starve), 0);
    rst_n = 1'b1;

    // directed vector table
    for (int i = 0; i < 14; i++) begin
      drive({tbl[i].w, tbl[i].e, tbl[i].s, tbl[i].n},
            tbl[i].flit, tbl[i].vld);
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_nout", i),
          32'(bus.nout), 32'(tbl[i].en));
      chk($sformatf("tbl%0d_sout", i),
          32'(bus.sout), 32'(tbl[i].es));
      chk($sformatf("tbl%0d_eout", i),
          32'(bus.eout), 32'(tbl[i].ee));
      chk($sformatf("tbl%0d_wout", i),
          32'(bus.wout), 32'(tbl[i].ew));
      chk($sformatf("tbl%0d_cnt", i),
          32'(bus.fifo_cnt), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_ready", i),
          32'(bus.inj_ready), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_starve", i),
          32'(bus.starve), 0);
    end

    // starvation: all slots busy for 20 cycles
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cycle(all_v, 10'(10'h030 + i), i < 4);
      if (i == 3) begin
        chk("stv_full_cnt", 32'(bus.fifo_cnt), 4);
        chk("stv_full_rdy", 32'(bus.inj_ready), 0);
      end
      chk($sformatf("stv_flag_%0d", i), 32'(bus.starve),
          32'(STARVE_EN && i >= LIMIT));
    end
    rch = all_v;
    rch[3] = 10'h000;
    cycle(rch, 10'h000, 1'b0);
    chk("stv_clear", 32'(bus.starve), 0);
    chk("stv_clear_w", 32'(bus.wout), 32'h230);

    // asynchronous reset in the middle of a cycle
    do_reset();
    for (int i = 0; i < 3; i++)
      cycle(all_v, 10'(10'h040 + i), 1'b1);
    chk("ar_pre_cnt", 32'(bus.fifo_cnt), 3);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_nout", 32'(bus.nout), 0);
    chk("ar_sout", 32'(bus.sout), 0);
    chk("ar_eout", 32'(bus.eout), 0);
    chk("ar_wout", 32'(bus.wout), 0);
    chk("ar_cnt", 32'(bus.fifo_cnt), 0);
    chk("ar_ready", 32'(bus.inj_ready), 1);
    #2;
    rst_n = 1'b1;
    mq.delete();
    mblk = 0;
    drive(all_v, 10'h077, 1'b1);
    @(posedge clk);
    #1;
    chk("ar_first_push", 32'(bus.fifo_cnt), 1);
    drive('0, 10'h000, 1'b0);
    @(posedge clk);
    #1;
    chk("ar_first_out", 32'(bus.nout), 32'h277);
    chk("ar_empty", 32'(bus.fifo_cnt), 0);

    // randomized traffic against the model
    do_reset();
    for (int b = 0; b < 30; b++) begin
      p = (b % 3 == 0) ? 97 : ((b % 3 == 1) ? 50 : 80);
      for (int c = 0; c < 100; c++) begin
        for (int k = 0; k < 4; k++) begin
          rch[k][8:0] = 9'($urandom);
          rch[k][9]   = ($urandom_range(0, 99) < p);
        end
        cycle(rch, 10'($urandom),
              ($urandom_range(0, 99) < 60));
      end
    end

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end
endmodule
